// File: rtl/aes128_inv_key_sched.sv
// AES-128 decryption key scheduler: emits round keys 10 down to 0, rebuilding
// each key from its successor so only a single 128-bit key is ever stored.
module aes128_inv_key_sched #(
  parameter int unsigned NK = 4,
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         key_is_last,
  input  logic [0:127] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  localparam int unsigned key_w = 32 * NK;
  localparam int unsigned rnd_w = 4;

  // Forward AES S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return sbox_tbl[11'(2047 - 8 * int'(a)) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [rnd_w-1:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t           state_q, state_d;
  logic [key_w-1:0] key_q, key_d;
  logic [rnd_w-1:0] cnt_q, cnt_d, round_q, round_d;
  logic             busy_q, valid_q, last_q;
  logic             busy_d, valid_d, last_d;

  logic [31:0]      w0, w1, w2, w3, inv_w3, sub_in, rot, t_word;
  logic [31:0]      f0, f1, f2, f3;
  logic [rnd_w-1:0] rcon_idx;
  logic [key_w-1:0] fwd_key, inv_key;

  // One SubWord path serves both directions: FWD feeds w3, EMIT feeds the recovered w3.
  always_comb begin
    w0       = key_q[127:96];
    w1       = key_q[95:64];
    w2       = key_q[63:32];
    w3       = key_q[31:0];
    inv_w3   = w3 ^ w2;
    sub_in   = (state_q == EMIT) ? inv_w3 : w3;
    rcon_idx = (state_q == EMIT) ? round_q : cnt_q;
    rot      = {sub_in[23:0], sub_in[31:24]};
    t_word   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon(rcon_idx), 24'h000000};
    f0       = w0 ^ t_word;
    f1       = w1 ^ f0;
    f2       = w2 ^ f1;
    f3       = w3 ^ f2;
    fwd_key  = {f0, f1, f2, f3};
    inv_key  = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, inv_w3};
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d = key_in;
          if (key_is_last) begin
            round_d = rnd_w'(NR);
            state_d = EMIT;
          end else begin
            cnt_d   = rnd_w'(1);
            state_d = FWD;
          end
        end
      end
      FWD: begin
        key_d = fwd_key;
        if (cnt_q == rnd_w'(NR)) begin
          cnt_d   = '0;
          round_d = rnd_w'(NR);
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + rnd_w'(1);
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (round_q != '0) begin
            key_d   = inv_key;
            round_d = round_q - rnd_w'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == EMIT);
    last_d  = (state_d == EMIT) && (round_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_out   = key_q;
  assign rk_round = round_q;
  assign rk_last  = last_q;

endmodule
